// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing the single RAM/IO port between instruction fetch and the LSB.
// Multi-byte requests become consecutive byte transactions; all bus outputs are registered.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  clear_in,
    input  logic                  if_valid_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  lsb_valid_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
    input  logic [31:0]           lsb_wdata_in,
    output logic                  lsb_done_out,
    output logic [31:0]           lsb_rdata_out,
    input  logic [7:0]            mem_din_in,
    output logic [7:0]            mem_dout_out,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out,
    input  logic                  io_buffer_full_in
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            k, k_nxt;
    logic [2:0]            len, len_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [31:0]           wdata, wdata_nxt;
    logic [31:0]           rbuf, rbuf_nxt;
    logic                  own_lsb, own_lsb_nxt;
    logic                  last_lsb, last_lsb_nxt;
    logic                  if_done_nxt, lsb_done_nxt;
    logic [31:0]           if_data_nxt, lsb_rdata_nxt;
    logic [ADDR_WIDTH-1:0] a_nxt;
    logic                  wr_nxt;
    logic [7:0]            dout_nxt;
    logic                  if_elig, lsb_elig, pick_lsb, pick_if;
    logic                  io_blk, issue;
    logic [2:0]            issue_k;
    logic [7:0]            wbyte;

    // a store to the UART window must wait while its TX buffer is full
    assign io_blk = (addr[17:16] == 2'b11) && io_buffer_full_in;

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        len_nxt       = len;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        rbuf_nxt      = rbuf;
        own_lsb_nxt   = own_lsb;
        last_lsb_nxt  = last_lsb;
        if_done_nxt   = 1'b0;
        lsb_done_nxt  = 1'b0;
        if_data_nxt   = if_data_out;
        lsb_rdata_nxt = lsb_rdata_out;
        issue         = 1'b0;
        issue_k       = '0;
        if_elig       = if_valid_in && !if_done_out && !clear_in;
        lsb_elig      = lsb_valid_in && !lsb_done_out && !clear_in;
        pick_lsb      = lsb_elig && (!if_elig || !last_lsb);
        pick_if       = if_elig && !pick_lsb;

        unique case (state)
            IDLE: begin
                if (pick_lsb || pick_if) begin
                    own_lsb_nxt  = pick_lsb;
                    last_lsb_nxt = pick_lsb;
                    addr_nxt     = pick_lsb ? lsb_addr_in : if_addr_in;
                    wdata_nxt    = lsb_wdata_in;
                    rbuf_nxt     = '0;
                    k_nxt        = '0;
                    if (pick_if) begin
                        len_nxt = 3'd4;
                    end else begin
                        case (lsb_size_in)
                            2'b00:   len_nxt = 3'd1;
                            2'b01:   len_nxt = 3'd2;
                            default: len_nxt = 3'd4;
                        endcase
                    end
                    if (pick_lsb && lsb_wr_in) begin
                        state_nxt = WRITE;
                        issue     = !((lsb_addr_in[17:16] == 2'b11) && io_buffer_full_in);
                    end else begin
                        state_nxt = READ;
                        issue     = 1'b1;
                    end
                end
            end
            READ: begin
                if (clear_in) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                end else begin
                    // the byte on mem_din belongs to the address issued last cycle (k-1)
                    for (int b = 0; b < 4; b++)
                        if (k == 3'(b + 1)) rbuf_nxt[8*b +: 8] = mem_din_in;
                    if (k == len) begin
                        state_nxt = IDLE;
                        k_nxt     = '0;
                        if (own_lsb) begin
                            lsb_done_nxt  = 1'b1;
                            lsb_rdata_nxt = rbuf_nxt;
                        end else begin
                            if_done_nxt = 1'b1;
                            if_data_nxt = rbuf_nxt;
                        end
                    end else begin
                        k_nxt   = k + 3'd1;
                        issue   = (k_nxt < len);
                        issue_k = k_nxt;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_out) begin
                    if (k == len - 3'd1) begin
                        state_nxt    = IDLE;
                        k_nxt        = '0;
                        lsb_done_nxt = 1'b1;
                    end else begin
                        k_nxt   = k + 3'd1;
                        issue   = !io_blk;
                        issue_k = k_nxt;
                    end
                end else begin
                    issue   = !io_blk;
                    issue_k = k;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (issue_k[1:0])
            2'd0:    wbyte = wdata_nxt[7:0];
            2'd1:    wbyte = wdata_nxt[15:8];
            2'd2:    wbyte = wdata_nxt[23:16];
            default: wbyte = wdata_nxt[31:24];
        endcase
        a_nxt    = issue ? addr_nxt + ADDR_WIDTH'(issue_k) : '0;
        wr_nxt   = issue && (state_nxt == WRITE);
        dout_nxt = wr_nxt ? wbyte : 8'h00;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            k             <= '0;
            len           <= '0;
            addr          <= '0;
            wdata         <= '0;
            rbuf          <= '0;
            own_lsb       <= 1'b0;
            last_lsb      <= 1'b0;
            if_done_out   <= 1'b0;
            lsb_done_out  <= 1'b0;
            if_data_out   <= '0;
            lsb_rdata_out <= '0;
            mem_a_out     <= '0;
            mem_wr_out    <= 1'b0;
            mem_dout_out  <= '0;
        end else begin
            state         <= state_nxt;
            k             <= k_nxt;
            len           <= len_nxt;
            addr          <= addr_nxt;
            wdata         <= wdata_nxt;
            rbuf          <= rbuf_nxt;
            own_lsb       <= own_lsb_nxt;
            last_lsb      <= last_lsb_nxt;
            if_done_out   <= if_done_nxt;
            lsb_done_out  <= lsb_done_nxt;
            if_data_out   <= if_data_nxt;
            lsb_rdata_out <= lsb_rdata_nxt;
            mem_a_out     <= a_nxt;
            mem_wr_out    <= wr_nxt;
            mem_dout_out  <= dout_nxt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized requests
// checked against a transaction-level timing/data model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_in, if_valid_in, lsb_valid_in, lsb_wr_in, io_buffer_full_in;
    logic [31:0] if_addr_in, lsb_addr_in, lsb_wdata_in;
    logic [1:0]  lsb_size_in;
    logic        if_done_out, lsb_done_out, mem_wr_out;
    logic [31:0] if_data_out, lsb_rdata_out, mem_a_out;
    logic [7:0]  mem_din, mem_dout_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit lg_lsb;

    // bus-side RAM and an independent reference image, same indexing
    bit [7:0]  mem     [0:32767];
    bit [7:0]  ref_mem [0:32767];
    logic      poke_en = 1'b0;
    int        poke_idx;
    bit [7:0]  poke_val;
    bit        full_pat [0:63];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear_in),
        .if_valid_in(if_valid_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .lsb_valid_in(lsb_valid_in), .lsb_wr_in(lsb_wr_in), .lsb_size_in(lsb_size_in),
        .lsb_addr_in(lsb_addr_in), .lsb_wdata_in(lsb_wdata_in),
        .lsb_done_out(lsb_done_out), .lsb_rdata_out(lsb_rdata_out),
        .mem_din_in(mem_din), .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out),
        .mem_wr_out(mem_wr_out), .io_buffer_full_in(io_buffer_full_in)
    );

    function automatic int midx(input logic [31:0] a);
        return int'({a[17:16] == 2'b11, a[13:0]});
    endfunction

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (mem_wr_out) mem[midx(mem_a_out)] <= mem_dout_out;
        mem_din <= mem[midx(mem_a_out)];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input bit [7:0] v);
        poke_idx = midx(a); poke_val = v; poke_en = 1'b1;
        ref_mem[midx(a)] = v;
        tick();
        poke_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < n; j++) w[8*j +: 8] = ref_mem[midx(a + 32'(j))];
        return w;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; clear_in = 0; if_valid_in = 0; lsb_valid_in = 0; lsb_wr_in = 0;
        io_buffer_full_in = 0; if_addr_in = 0; lsb_addr_in = 0; lsb_wdata_in = 0; lsb_size_in = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lg_lsb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({mem_a_out, mem_wr_out, mem_dout_out, if_done_out, lsb_done_out} !== '0) begin
            n_fail++; $display("FAIL reset_bus: got a=%h wr=%b d=%h ifd=%b lsbd=%b, want all 0",
                               mem_a_out, mem_wr_out, mem_dout_out, if_done_out, lsb_done_out);
        end
        n_checks++;
        if (if_data_out !== 32'h0 || lsb_rdata_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got if=%h lsb=%h, want 0", if_data_out, lsb_rdata_out);
        end
        // reset in the middle of a store
        lsb_valid_in = 1; lsb_wr_in = 1; lsb_size_in = 2'b10; lsb_addr_in = 32'h2100;
        lsb_wdata_in = 32'h11223344;
        tick(); tick();
        rst_n = 1'b0; lsb_valid_in = 0;
        #1;
        n_checks++;
        if (mem_wr_out !== 1'b0 || mem_a_out !== 32'h0 || lsb_done_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got wr=%b a=%h done=%b, want 0 0 0",
                               mem_wr_out, mem_a_out, lsb_done_out);
        end
        ref_mem[midx(32'h2100)] = 8'h44;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (lsb_done_out !== 1'b0 || mem_wr_out !== 1'b0) begin
                n_fail++; $display("FAIL reset_nodone cycle %0d: got done=%b wr=%b, want 0 0",
                                   c, lsb_done_out, mem_wr_out);
            end
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_a;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        if_addr_in = 32'h100; if_valid_in = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_a = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
            n_checks++;
            if (mem_a_out !== exp_a || mem_wr_out !== 1'b0) begin
                n_fail++; $display("FAIL fetch_addr cycle %0d: got a=%h wr=%b, want a=%h wr=0",
                                   c, mem_a_out, mem_wr_out, exp_a);
            end
            n_checks++;
            if (if_done_out !== (c == 6)) begin
                n_fail++; $display("FAIL fetch_done cycle %0d: got %b, want %b", c, if_done_out, c == 6);
            end
            if (c == 6) begin
                n_checks++;
                if (if_data_out !== 32'h00000513) begin
                    n_fail++; $display("FAIL fetch_data: got %h, want 00000513", if_data_out);
                end
                if_valid_in = 0;
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] w;
        w = 32'hDEADBEEF;
        lsb_valid_in = 1; lsb_wr_in = 1; lsb_size_in = 2'b10; lsb_addr_in = 32'h2000; lsb_wdata_in = w;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (c <= 4) begin
                if (mem_wr_out !== 1'b1 || mem_a_out !== 32'h2000 + 32'(c - 1) ||
                    mem_dout_out !== w[8*(c-1) +: 8]) begin
                    n_fail++; $display("FAIL store_byte cycle %0d: got wr=%b a=%h d=%h, want 1 %h %h",
                                       c, mem_wr_out, mem_a_out, mem_dout_out,
                                       32'h2000 + 32'(c - 1), w[8*(c-1) +: 8]);
                end
            end else if (mem_wr_out !== 1'b0 || mem_a_out !== 32'h0 || mem_dout_out !== 8'h0) begin
                n_fail++; $display("FAIL store_idle cycle %0d: got wr=%b a=%h d=%h, want 0 0 0",
                                   c, mem_wr_out, mem_a_out, mem_dout_out);
            end
            n_checks++;
            if (lsb_done_out !== (c == 5)) begin
                n_fail++; $display("FAIL store_done cycle %0d: got %b, want %b", c, lsb_done_out, c == 5);
            end
            if (c == 5) lsb_valid_in = 0;
        end
        for (int j = 0; j < 4; j++) ref_mem[midx(32'h2000 + 32'(j))] = w[8*j +: 8];
        n_checks++;
        if (mem[midx(32'h2003)] !== 8'hDE) begin
            n_fail++; $display("FAIL store_mem: got %h, want de", mem[midx(32'h2003)]);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_a;
        do_reset();
        lsb_valid_in = 1; lsb_wr_in = 0; lsb_size_in = 2'b00; lsb_addr_in = 32'h40;
        if_valid_in = 1; if_addr_in = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_a = (c == 1) ? 32'h40 : (c >= 4 && c <= 7) ? 32'h10 + 32'(c - 4) : 32'h0;
            n_checks++;
            if (mem_a_out !== exp_a) begin
                n_fail++; $display("FAIL cont_addr cycle %0d: got %h, want %h", c, mem_a_out, exp_a);
            end
            n_checks++;
            if (lsb_done_out !== (c == 3) || if_done_out !== (c == 9)) begin
                n_fail++; $display("FAIL cont_done cycle %0d: got lsb=%b if=%b, want %b %b",
                                   c, lsb_done_out, if_done_out, c == 3, c == 9);
            end
            if (c == 3) begin
                n_checks++;
                if (lsb_rdata_out !== ref_word(32'h40, 1)) begin
                    n_fail++; $display("FAIL cont_lsb_data: got %h, want %h", lsb_rdata_out, ref_word(32'h40, 1));
                end
                lsb_valid_in = 0;
            end
            if (c == 9) begin
                n_checks++;
                if (if_data_out !== ref_word(32'h10, 4)) begin
                    n_fail++; $display("FAIL cont_if_data: got %h, want %h", if_data_out, ref_word(32'h10, 4));
                end
                if_valid_in = 0;
            end
        end
        lg_lsb = 1'b0;
    endtask

    task automatic test_io_stall();
        lsb_valid_in = 1; lsb_wr_in = 1; lsb_size_in = 2'b00; lsb_addr_in = 32'h30000;
        lsb_wdata_in = 32'hAABBCC41; io_buffer_full_in = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            io_buffer_full_in = (c < 3);
            n_checks++;
            if (mem_wr_out !== (c == 4) || mem_a_out !== ((c == 4) ? 32'h30000 : 32'h0) ||
                mem_dout_out !== ((c == 4) ? 8'h41 : 8'h00)) begin
                n_fail++; $display("FAIL io_stall cycle %0d: got wr=%b a=%h d=%h", c, mem_wr_out, mem_a_out, mem_dout_out);
            end
            n_checks++;
            if (lsb_done_out !== (c == 5)) begin
                n_fail++; $display("FAIL io_done cycle %0d: got %b, want %b", c, lsb_done_out, c == 5);
            end
            if (c == 5) lsb_valid_in = 0;
        end
        ref_mem[midx(32'h30000)] = 8'h41;
    endtask

    task automatic test_clear();
        logic [31:0] w, exp_a;
        if_valid_in = 1; if_addr_in = 32'h20;
        for (int c = 1; c <= 8; c++) begin
            tick();
            clear_in = (c == 3);
            if (c == 3) if_valid_in = 0;
            exp_a = (c <= 3) ? 32'h20 + 32'(c - 1) : 32'h0;
            n_checks++;
            if (if_done_out !== 1'b0 || mem_a_out !== exp_a) begin
                n_fail++; $display("FAIL clear_fetch cycle %0d: got done=%b a=%h, want 0 %h",
                                   c, if_done_out, mem_a_out, exp_a);
            end
        end
        w = $urandom;
        lsb_valid_in = 1; lsb_wr_in = 1; lsb_size_in = 2'b11; lsb_addr_in = 32'h50; lsb_wdata_in = w;
        for (int c = 1; c <= 6; c++) begin
            tick();
            clear_in = (c == 3);
            n_checks++;
            if (mem_wr_out !== (c <= 4) || lsb_done_out !== (c == 5)) begin
                n_fail++; $display("FAIL clear_store cycle %0d: got wr=%b done=%b, want %b %b",
                                   c, mem_wr_out, lsb_done_out, c <= 4, c == 5);
            end
            if (c == 5) lsb_valid_in = 0;
        end
        clear_in = 0;
        for (int j = 0; j < 4; j++) ref_mem[midx(32'h50 + 32'(j))] = w[8*j +: 8];
        n_checks++;
        if ({mem[midx(32'h53)], mem[midx(32'h52)], mem[midx(32'h51)], mem[midx(32'h50)]} !== w) begin
            n_fail++; $display("FAIL clear_store_mem: got %h%h%h%h, want %h", mem[midx(32'h53)],
                               mem[midx(32'h52)], mem[midx(32'h51)], mem[midx(32'h50)], w);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        // a full-word load first, so the zero-extension below is observable
        lsb_valid_in = 1; lsb_wr_in = 0; lsb_size_in = 2'b10; lsb_addr_in = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (lsb_done_out) lsb_valid_in = 0;
        end
        poke(32'hFFFFFFFF, 8'h9C);
        exp = {16'h0, ref_mem[midx(32'h0)], 8'h9C};
        lsb_valid_in = 1; lsb_size_in = 2'b01; lsb_addr_in = 32'hFFFFFFFF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++;
            if (mem_a_out !== ((c == 1) ? 32'hFFFFFFFF : 32'h0) || lsb_done_out !== (c == 4)) begin
                n_fail++; $display("FAIL wrap cycle %0d: got a=%h done=%b", c, mem_a_out, lsb_done_out);
            end
            if (c == 4) begin
                n_checks++;
                if (lsb_rdata_out !== exp) begin
                    n_fail++; $display("FAIL wrap_data: got %h, want %h", lsb_rdata_out, exp);
                end
                lsb_valid_in = 0;
            end
        end
    endtask

    // completion cycle of a transaction granted in cycle t, from the timing rules
    function automatic int model_done(input int t, input bit wr, input bit io, input int n);
        int c;
        if (!wr) return t + n + 2;
        c = t;
        for (int j = 0; j < n; j++) begin
            c++;
            while (io && c < 63 && full_pat[c-1]) c++;
        end
        return c + 1;
    endfunction

    task automatic test_random();
        int mode, n, t, exp_if, exp_lsb, got_if, got_lsb;
        bit l_wr, l_io, lsb_first;
        logic [31:0] f_addr, l_addr, l_wd, exp_if_d, exp_lsb_d, got_if_d, got_lsb_d;
        logic [1:0] l_size;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            f_addr = 32'($urandom_range(0, 124));
            l_wr = 1'($urandom_range(0, 1)); l_io = 1'($urandom_range(0, 1));
            l_size = 2'($urandom_range(0, 3));
            l_addr = (l_io ? 32'h30000 : 32'h0) + 32'($urandom_range(0, 124));
            l_wd = $urandom;
            n = (l_size == 2'b00) ? 1 : (l_size == 2'b01) ? 2 : 4;
            for (int c = 0; c < 64; c++) full_pat[c] = ($urandom_range(0, 2) == 0);
            lsb_first = (mode == 1) || (mode == 2 && !lg_lsb);
            exp_if = -1; exp_lsb = -1; exp_if_d = 'x; exp_lsb_d = 'x; t = 0;
            for (int s = 0; s < 2; s++) begin
                if ((s == 0) == lsb_first && mode != 0) begin
                    exp_lsb = model_done(t, l_wr, l_io, n);
                    if (l_wr) for (int j = 0; j < n; j++) ref_mem[midx(l_addr + 32'(j))] = l_wd[8*j +: 8];
                    else exp_lsb_d = ref_word(l_addr, n);
                    t = exp_lsb; lg_lsb = 1'b1;
                end else if ((s == 0) != lsb_first && mode != 1) begin
                    exp_if = model_done(t, 1'b0, 1'b0, 4);
                    exp_if_d = ref_word(f_addr, 4);
                    t = exp_if; lg_lsb = 1'b0;
                end
            end
            if_valid_in = (mode != 1); if_addr_in = f_addr;
            lsb_valid_in = (mode != 0); lsb_wr_in = l_wr; lsb_size_in = l_size;
            lsb_addr_in = l_addr; lsb_wdata_in = l_wd; io_buffer_full_in = full_pat[0];
            got_if = -1; got_lsb = -1; got_if_d = '0; got_lsb_d = '0;
            for (int c = 1; c < 60; c++) begin
                tick();
                io_buffer_full_in = full_pat[c];
                if (if_done_out) begin got_if = c; got_if_d = if_data_out; if_valid_in = 0; end
                if (lsb_done_out) begin got_lsb = c; got_lsb_d = lsb_rdata_out; lsb_valid_in = 0; end
            end
            if_valid_in = 0; lsb_valid_in = 0; io_buffer_full_in = 0;
            n_checks++;
            if (got_if != exp_if || got_lsb != exp_lsb) begin
                n_fail++; $display("FAIL rand_timing it %0d mode %0d: got if@%0d lsb@%0d, want if@%0d lsb@%0d",
                                   it, mode, got_if, got_lsb, exp_if, exp_lsb);
            end
            if (mode != 1) begin
                n_checks++;
                if (got_if_d !== exp_if_d) begin
                    n_fail++; $display("FAIL rand_if_data it %0d: got %h, want %h", it, got_if_d, exp_if_d);
                end
            end
            if (mode != 0) begin
                n_checks++;
                if (l_wr && {mem[midx(l_addr + 32'd3)], mem[midx(l_addr + 32'd2)], mem[midx(l_addr + 32'd1)],
                             mem[midx(l_addr)]} !== ref_word(l_addr, 4)) begin
                    n_fail++; $display("FAIL rand_store_mem it %0d: addr %h, want %h", it, l_addr, ref_word(l_addr, 4));
                end else if (!l_wr && got_lsb_d !== exp_lsb_d) begin
                    n_fail++; $display("FAIL rand_lsb_data it %0d: got %h, want %h", it, got_lsb_d, exp_lsb_d);
                end
            end
        end
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 128; i++) begin
            poke(32'(i), 8'($urandom_range(1, 255)));
            poke(32'h30000 + 32'(i), 8'($urandom_range(1, 255)));
        end
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_io_stall();
        test_clear();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
